iob_rr_merge: RTL and testbench

- Round-robin arbiter that shares one native IOb slave bus between N_MASTERS native IOb master buses.
- Typical use: the instruction and data sides of the CPU sharing external memory, or several bus masters sharing one peripheral bus.
- Each slave transaction is owned by exactly one master; the response is routed back only to the owner.
- A watchdog terminates transactions the slave never acknowledges.

---
 rtl/iob_rr_merge_pkg.sv | 51 +++++
 rtl/iob_rr_arbiter.sv | 38 +++
 rtl/iob_rr_merge.sv | 133 +++++++++++++
 tb/tb_iob_rr_merge.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_rr_merge_pkg.sv
// Shared definitions for the round-robin IOb merge.
// Request word layout, MSB first: {valid, addr, wdata, wstrb}.
// Response word layout, MSB first: {rdata, ready}.
// The field helpers take the bus widths, so every user agrees on one layout.
package iob_rr_merge_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Widest data bus supported; the error pattern is sliced from this.
  parameter int unsigned MaxDataW = 1024;
  // rdata returned to a master whose transaction the watchdog aborted.
  localparam logic [MaxDataW-1:0] ErrDataAll = '1;

  function automatic int unsigned req_w(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int unsigned resp_w(input int unsigned dw);
    return dw + 1;
  endfunction

  // Request field positions (LSB of each field).
  function automatic int unsigned wstrb_lsb();
    return 0;
  endfunction

  function automatic int unsigned wdata_lsb(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return dw / 8 + dw;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned aw, input int unsigned dw);
    return dw / 8 + dw + aw;
  endfunction

  // Response field positions.
  function automatic int unsigned ready_bit();
    return 0;
  endfunction

  function automatic int unsigned rdata_lsb();
    return 1;
  endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Rotating-priority grant.
// Ports:
//   req      request vector, one bit per requester
//   ptr      index with highest priority this round
//   gnt      one-hot grant (all zero when nothing requests)
//   gnt_idx  binary index of the granted requester
//   any_req  at least one request is present
// Search starts at ptr and goes up in index order with wrap-around.
module iob_rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [PtrW-1:0] gnt_idx,
  output logic            any_req
);

  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PtrW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/iob_rr_merge.sv
// Round-robin merge of N_MASTERS native IOb master buses onto one slave bus.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   m_req        packed master requests {valid, addr, wdata, wstrb}, master 0 in the LSBs
//   m_resp       packed master responses {rdata, ready}, only the owner ever sees ready
//   s_req        registered slave request
//   s_resp       slave response {rdata, ready}
//   timeout_err  one-cycle pulse when the watchdog aborts a transaction
//   owner        index of the current or last grantee
// One transaction at a time: IDLE grants and latches a request, BUSY waits for
// the slave (or the watchdog), then one IDLE cycle lets the master drop valid.
module iob_rr_merge
  import iob_rr_merge_pkg::*;
#(
  parameter int unsigned  N_MASTERS = 2,
  parameter int unsigned  ADDR_W    = 32,
  parameter int unsigned  DATA_W    = 32,
  parameter int unsigned  TIMEOUT_W = 10,
  localparam int unsigned ReqW      = req_w(ADDR_W, DATA_W),
  localparam int unsigned RespW     = resp_w(DATA_W),
  localparam int unsigned OwnW      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTERS*ReqW-1:0]  m_req,
  output logic [N_MASTERS*RespW-1:0] m_resp,
  output logic [ReqW-1:0]            s_req,
  input  logic [RespW-1:0]           s_resp,
  output logic                       timeout_err,
  output logic [OwnW-1:0]            owner
);

  localparam int unsigned ValidBit = valid_bit(ADDR_W, DATA_W);
  localparam int unsigned WdW      = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  // wd_q counts BUSY cycles already elapsed, so the cycle with wd_q == WdLast
  // is BUSY cycle number 2^TIMEOUT_W-1.
  localparam logic [WdW-1:0] WdLast =
      (TIMEOUT_W > 0) ? WdW'((32'd1 << TIMEOUT_W) - 32'd2) : '0;

  state_e          state_q;
  logic [OwnW-1:0] ptr_q;
  logic [OwnW-1:0] owner_q;
  logic [ReqW-1:0] s_req_q;
  logic [WdW-1:0]  wd_q;

  logic [N_MASTERS-1:0] req_vec;
  logic [N_MASTERS-1:0] gnt;
  logic [OwnW-1:0]      gnt_idx;
  logic                 any_req;
  logic [ReqW-1:0]      gnt_req;
  logic                 busy;
  logic                 slave_ready;
  logic                 wd_hit;
  logic                 done;
  logic                 abort;
  logic [OwnW-1:0]      ptr_next;

  always_comb begin
    req_vec = '0;
    gnt_req = '0;
    for (int m = 0; m < int'(N_MASTERS); m++) begin
      req_vec[m] = m_req[m*ReqW + ValidBit];
      if (gnt[m]) gnt_req = gnt_req | m_req[m*ReqW +: ReqW];
    end
  end

  iob_rr_arbiter #(
    .N    (N_MASTERS),
    .PtrW (OwnW)
  ) u_arbiter (
    .req     (req_vec),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  assign busy        = (state_q == StBusy);
  assign slave_ready = s_resp[ready_bit()];
  assign wd_hit      = (TIMEOUT_W != 0) && (wd_q == WdLast);
  assign done        = busy && slave_ready;
  // A slave ready in the timeout cycle takes precedence over the abort.
  assign abort       = busy && !slave_ready && wd_hit;
  assign ptr_next    = OwnW'((32'(owner_q) + 32'd1) % N_MASTERS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      s_req_q <= '0;
      wd_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q <= gnt_idx;
            s_req_q <= gnt_req;
            wd_q    <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (done || abort) begin
            s_req_q[ValidBit] <= 1'b0;
            ptr_q             <= ptr_next;
            state_q           <= StIdle;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Response routing: only the owner sees the slave, and only while BUSY.
  always_comb begin
    m_resp = '0;
    for (int m = 0; m < int'(N_MASTERS); m++) begin
      if (busy && (owner_q == OwnW'(m))) begin
        if (abort) m_resp[m*RespW +: RespW] = {ErrDataAll[DATA_W-1:0], 1'b1};
        else       m_resp[m*RespW +: RespW] = s_resp;
      end
    end
  end

  assign timeout_err = abort;
  assign s_req       = s_req_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_iob_rr_merge.sv
// Bench for iob_rr_merge: two masters, 32-bit buses, 3-bit watchdog (7 cycles).
module tb_iob_rr_merge;

  localparam int N      = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TW     = 3;
  localparam int SW     = DW / 8;
  localparam int REQ_W  = 1 + AW + DW + SW;
  localparam int RESP_W = DW + 1;
  localparam int OW     = 1;
  localparam int WD_CYC = (1 << TW) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N*REQ_W-1:0]    m_req;
  logic [N*RESP_W-1:0]   m_resp;
  logic [REQ_W-1:0]      s_req;
  logic [RESP_W-1:0]     s_resp;
  logic                  timeout_err;
  logic [OW-1:0]         owner;

  int n_checks = 0;
  int n_pass   = 0;
  int model_ptr = 0;

  iob_rr_merge #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .m_resp      (m_resp),
    .s_req       (s_req),
    .s_resp      (s_resp),
    .timeout_err (timeout_err),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [AW-1:0] a,
                                              input logic [DW-1:0] d, input logic [SW-1:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [RESP_W-1:0] resp_of(input int m);
    return m_resp[m*RESP_W +: RESP_W];
  endfunction

  // Round-robin rule: first pending master at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_m(input int m, input logic [REQ_W-1:0] r);
    m_req[m*REQ_W +: REQ_W] = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = '0; s_resp = '0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (s_req !== '0) $display("FAIL reset_sreq: got %h want 0", s_req);
    else n_pass++;
    n_checks++; if (m_resp !== '0) $display("FAIL reset_mresp: got %h want 0", m_resp);
    else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_terr: got %b want 0", timeout_err);
    else n_pass++;
    n_checks++; if (owner !== '0) $display("FAIL reset_owner: got %0d want 0", owner);
    else n_pass++;
    tick(); tick();
    rst = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_read();
    logic [REQ_W-1:0] r;
    r = mk_req(1'b1, 32'h100, '0, '0);
    set_m(0, r);
    #1;
    n_checks++; if (s_req[REQ_W-1] !== 1'b0) $display("FAIL read_early: got %b want 0", s_req[REQ_W-1]);
    else n_pass++;
    tick();
    n_checks++; if (s_req !== r) $display("FAIL read_sreq: got %h want %h", s_req, r);
    else n_pass++;
    n_checks++; if (owner !== 1'b0) $display("FAIL read_owner: got %0d want 0", owner);
    else n_pass++;
    n_checks++; if (m_resp !== '0) $display("FAIL read_wait: got %h want 0", m_resp);
    else n_pass++;
    tick(); tick();
    s_resp = {32'hCAFE0001, 1'b1};
    #1;
    n_checks++;
    if (resp_of(0) !== {32'hCAFE0001, 1'b1}) $display("FAIL read_resp0: got %h want %h",
                                                      resp_of(0), {32'hCAFE0001, 1'b1});
    else n_pass++;
    n_checks++; if (resp_of(1) !== '0) $display("FAIL read_resp1: got %h want 0", resp_of(1));
    else n_pass++;
    tick();
    s_resp = '0; set_m(0, '0);
    model_ptr = 1;
    n_checks++; if (s_req[REQ_W-1] !== 1'b0) $display("FAIL read_done: got %b want 0", s_req[REQ_W-1]);
    else n_pass++;
  endtask

  task automatic test_fairness();
    logic [REQ_W-1:0] pl [N];
    int cnt [N];
    int exp;
    logic [DW-1:0] rd;
    for (int m = 0; m < N; m++) begin
      pl[m] = mk_req(1'b1, $urandom, $urandom, SW'($urandom));
      set_m(m, pl[m]);
      cnt[m] = 0;
    end
    for (int t = 0; t < 20; t++) begin
      exp = pick('1, model_ptr);
      tick();
      n_checks++; if (owner !== OW'(exp)) $display("FAIL fair_owner[%0d]: got %0d want %0d", t, owner, exp);
      else n_pass++;
      n_checks++; if (s_req !== pl[exp]) $display("FAIL fair_sreq[%0d]: got %h want %h", t, s_req, pl[exp]);
      else n_pass++;
      rd = $urandom;
      s_resp = {rd, 1'b1};
      #1;
      n_checks++;
      if (resp_of(exp) !== {rd, 1'b1}) $display("FAIL fair_resp[%0d]: got %h want %h", t,
                                                resp_of(exp), {rd, 1'b1});
      else n_pass++;
      n_checks++;
      if (resp_of(1 - exp) !== '0) $display("FAIL fair_other[%0d]: got %h want 0", t, resp_of(1 - exp));
      else n_pass++;
      tick();
      s_resp = '0;
      cnt[exp]++;
      model_ptr = (exp + 1) % N;
      pl[exp] = mk_req(1'b1, $urandom, $urandom, SW'($urandom));
      set_m(exp, pl[exp]);
      n_checks++; if (s_req[REQ_W-1] !== 1'b0) $display("FAIL fair_idle[%0d]: got 1 want 0", t);
      else n_pass++;
    end
    m_req = '0;
    n_checks++;
    if (cnt[0] != 10 || cnt[1] != 10) $display("FAIL fair_count: got %0d/%0d want 10/10", cnt[0], cnt[1]);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [REQ_W-1:0] w;
    int l;
    w = mk_req(1'b1, 32'h20, 32'h55AA, 4'hF);
    set_m(1, w);
    tick();
    n_checks++; if (s_req !== w) $display("FAIL write_sreq: got %h want %h", s_req, w);
    else n_pass++;
    n_checks++; if (owner !== OW'(pick(2'b10, model_ptr))) $display("FAIL write_owner: got %0d want 1", owner);
    else n_pass++;
    l = $urandom_range(0, 3);
    repeat (l) tick();
    s_resp = {32'($urandom), 1'b1};
    #1;
    n_checks++; if (resp_of(1)[0] !== 1'b1) $display("FAIL write_ready1: got 0 want 1");
    else n_pass++;
    n_checks++; if (resp_of(0) !== '0) $display("FAIL write_ready0: got %h want 0", resp_of(0));
    else n_pass++;
    tick();
    s_resp = '0; m_req = '0;
    model_ptr = 0;
    // Both request: the pointer after master 1 must favour master 0.
    set_m(0, mk_req(1'b1, 32'h4, '0, '0));
    set_m(1, mk_req(1'b1, 32'h8, '0, '0));
    tick();
    n_checks++; if (owner !== OW'(pick(2'b11, model_ptr))) $display("FAIL write_ptr: got %0d want 0", owner);
    else n_pass++;
    s_resp = {32'h0, 1'b1};
    tick();
    s_resp = '0; m_req = '0;
    model_ptr = 1;
  endtask

  task automatic test_timeout();
    set_m(0, mk_req(1'b1, 32'h40, '0, '0));
    tick();
    for (int c = 1; c <= WD_CYC; c++) begin
      if (c < WD_CYC) begin
        n_checks++; if (timeout_err !== 1'b0 || resp_of(0)[0] !== 1'b0)
          $display("FAIL to_early[%0d]: got err=%b rdy=%b want 0/0", c, timeout_err, resp_of(0)[0]);
        else n_pass++;
        tick();
      end
    end
    n_checks++; if (resp_of(0) !== {32'hFFFFFFFF, 1'b1})
      $display("FAIL to_resp: got %h want %h", resp_of(0), {32'hFFFFFFFF, 1'b1});
    else n_pass++;
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_pulse: got 0 want 1");
    else n_pass++;
    n_checks++; if (resp_of(1) !== '0) $display("FAIL to_other: got %h want 0", resp_of(1));
    else n_pass++;
    tick();
    m_req = '0;
    model_ptr = 1;
    n_checks++; if (s_req[REQ_W-1] !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL to_after: got v=%b err=%b want 0/0", s_req[REQ_W-1], timeout_err);
    else n_pass++;
    // Slave ready in the timeout cycle wins.
    set_m(0, mk_req(1'b1, 32'h44, '0, '0));
    tick();
    for (int c = 1; c < WD_CYC; c++) tick();
    s_resp = {32'h12345678, 1'b1};
    #1;
    n_checks++; if (resp_of(0) !== {32'h12345678, 1'b1})
      $display("FAIL to_race_resp: got %h want %h", resp_of(0), {32'h12345678, 1'b1});
    else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_race_err: got 1 want 0");
    else n_pass++;
    tick();
    s_resp = '0; m_req = '0;
    model_ptr = 1;
    n_checks++; if (s_req[REQ_W-1] !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL to_race_after: got v=%b err=%b want 0/0", s_req[REQ_W-1], timeout_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_m(1, mk_req(1'b1, 32'h80, 32'h1, 4'h3));
    tick();
    n_checks++; if (owner !== 1'b1) $display("FAIL rmid_owner: got %0d want 1", owner);
    else n_pass++;
    tick();
    s_resp = {32'hDEAD, 1'b1};
    rst = 1'b0;
    #1;
    n_checks++; if (m_resp !== '0) $display("FAIL rmid_resp: got %h want 0", m_resp);
    else n_pass++;
    n_checks++; if (s_req[REQ_W-1] !== 1'b0) $display("FAIL rmid_valid: got 1 want 0");
    else n_pass++;
    s_resp = '0; m_req = '0;
    tick();
    rst = 1'b1;
    model_ptr = 0;
    set_m(0, mk_req(1'b1, 32'hC, '0, '0));
    set_m(1, mk_req(1'b1, 32'hD, '0, '0));
    tick();
    n_checks++; if (owner !== OW'(pick(2'b11, model_ptr))) $display("FAIL rmid_regrant: got %0d want 0", owner);
    else n_pass++;
    s_resp = {32'h0, 1'b1};
    tick();
    s_resp = '0; m_req = '0;
    model_ptr = 1;
  endtask

  task automatic test_drop_valid();
    logic [REQ_W-1:0] p;
    logic [DW-1:0] rd;
    p = mk_req(1'b1, $urandom, $urandom, '0);
    set_m(0, p);
    tick();
    n_checks++; if (s_req !== p) $display("FAIL drop_grant: got %h want %h", s_req, p);
    else n_pass++;
    set_m(0, ~p & ~(REQ_W'(1) << (REQ_W - 1)));
    tick();
    n_checks++; if (s_req !== p) $display("FAIL drop_hold1: got %h want %h", s_req, p);
    else n_pass++;
    tick();
    n_checks++; if (s_req !== p) $display("FAIL drop_hold2: got %h want %h", s_req, p);
    else n_pass++;
    rd = $urandom;
    s_resp = {rd, 1'b1};
    #1;
    n_checks++; if (resp_of(0) !== {rd, 1'b1}) $display("FAIL drop_resp: got %h want %h", resp_of(0), {rd, 1'b1});
    else n_pass++;
    tick();
    s_resp = '0;
    model_ptr = 1;
    tick();
    n_checks++; if (s_req[REQ_W-1] !== 1'b0) $display("FAIL drop_nogrant: got 1 want 0");
    else n_pass++;
    m_req = '0;
  endtask

  task automatic test_random();
    logic [REQ_W-1:0] pl [N];
    logic [N-1:0] pend;
    int exp;
    logic [DW-1:0] rd;
    pend = '0;
    for (int t = 0; t < 12; t++) begin
      for (int m = 0; m < N; m++) begin
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          pend[m] = 1'b1;
          pl[m] = mk_req(1'b1, $urandom, $urandom, SW'($urandom));
          set_m(m, pl[m]);
        end
      end
      if (pend == '0) begin
        exp = $urandom_range(0, N - 1);
        pend[exp] = 1'b1;
        pl[exp] = mk_req(1'b1, $urandom, $urandom, SW'($urandom));
        set_m(exp, pl[exp]);
      end
      exp = pick(pend, model_ptr);
      tick();
      n_checks++; if (owner !== OW'(exp) || s_req !== pl[exp])
        $display("FAIL rand_grant[%0d]: got %0d/%h want %0d/%h", t, owner, s_req, exp, pl[exp]);
      else n_pass++;
      repeat ($urandom_range(0, 5)) tick();
      rd = $urandom;
      s_resp = {rd, 1'b1};
      #1;
      n_checks++; if (resp_of(exp) !== {rd, 1'b1} || resp_of(1 - exp) !== '0)
        $display("FAIL rand_resp[%0d]: got %h want %h at master %0d", t, m_resp, {rd, 1'b1}, exp);
      else n_pass++;
      tick();
      s_resp = '0;
      pend[exp] = 1'b0;
      set_m(exp, '0);
      model_ptr = (exp + 1) % N;
    end
    m_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_fairness();
    test_write();
    test_timeout();
    test_reset_mid();
    test_drop_valid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
